// File: rtl/regfile_write_arbiter_pkg.sv
// Package regfile_arb_pkg: shared defaults, requester ids and age-stamp
// helpers for the register-file write arbiter.
package regfile_arb_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int AGE_W        = 2;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // Cycles elapsed since a slot was stamped. A slot never waits more than
  // two cycles, so the 2-bit difference never wraps.
  function automatic logic [AGE_W-1:0] age_of(input logic [AGE_W-1:0] now_cnt,
                                              input logic [AGE_W-1:0] stamp);
    return now_cnt - stamp;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus between the two writeback requesters / register file and the arbiter.
//   slave  : arbiter side (takes requests, drives the write port)
//   master : environment side (requesters and register file)
// Optional macro REG_FWD_EN adds the forwarding lookup signals.
interface regfile_write_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              reqValidA;
  logic              reqReadyA;
  logic [ADDR_W-1:0] reqAddrA;
  logic [DATA_W-1:0] reqDataA;
  logic              reqValidB;
  logic              reqReadyB;
  logic [ADDR_W-1:0] reqAddrB;
  logic [DATA_W-1:0] reqDataB;
  logic [ADDR_W-1:0] writeAddress;
  logic              writeEn;
  logic [DATA_W-1:0] writeData;
  logic              dropErr;
  logic              idle;
`ifdef REG_FWD_EN
  logic [ADDR_W-1:0] fwdAddrA;
  logic [ADDR_W-1:0] fwdAddrB;
  logic              fwdHitA;
  logic              fwdHitB;
  logic [DATA_W-1:0] fwdDataA;
  logic [DATA_W-1:0] fwdDataB;
`endif

  modport slave (
    input  reqValidA, reqAddrA, reqDataA,
    input  reqValidB, reqAddrB, reqDataB,
    output reqReadyA, reqReadyB,
    output writeAddress, writeEn, writeData, dropErr, idle
`ifdef REG_FWD_EN
    , input fwdAddrA, fwdAddrB
    , output fwdHitA, fwdHitB, fwdDataA, fwdDataB
`endif
  );

  modport master (
    output reqValidA, reqAddrA, reqDataA,
    output reqValidB, reqAddrB, reqDataB,
    input  reqReadyA, reqReadyB,
    input  writeAddress, writeEn, writeData, dropErr, idle
`ifdef REG_FWD_EN
    , output fwdAddrA, fwdAddrB
    , input fwdHitA, fwdHitB, fwdDataA, fwdDataB
`endif
  );
endinterface

// File: rtl/regfile_write_arbiter_slot.sv
// write_slot: one-deep holding register for a pending register write.
// Ports: clk, reset (sync, active-high); load_i captures addr/data/stamp and
// sets full (load wins over clear so a slot can refill as it drains);
// clear_i empties the slot; full_o/addr_o/data_o/stamp_o expose contents.
module write_slot
  import regfile_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [AGE_W-1:0]  stamp_i,
  output logic              full_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [AGE_W-1:0]  stamp_o
);
  logic              full_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [AGE_W-1:0]  stamp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      stamp_q <= '0;
    end else if (load_i) begin
      full_q  <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= data_i;
      stamp_q <= stamp_i;
    end else if (clear_i) begin
      full_q  <= 1'b0;
    end
  end

  assign full_o  = full_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign stamp_o = stamp_q;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between
// requester A (ALU result) and B (memory load), oldest pending write first.
// Ports: clk, reset (sync, active-high), bus (regfile_write_arbiter_if.slave):
//   reqValid/Ready/Addr/Data A and B, registered writeAddress/writeEn/
//   writeData, dropErr pulse for out-of-range writes, idle.
// Optional macro REG_FWD_EN: forwarding lookups fwdAddrA/B -> fwdHitA/B,
// fwdDataA/B against pending slots and the in-flight write.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  bus
);
  localparam logic [ADDR_W:0] NUM_REGS_LIM = (ADDR_W+1)'(NUM_REGS);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NUM_REGS_LIM;
  endfunction

  logic [AGE_W-1:0]  cnt_q;
  req_id_e           ptr_q, ptr_d;
  logic              we_q, we_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  logic              full_a, full_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] data_a, data_b;
  logic [AGE_W-1:0]  stamp_a, stamp_b;
  logic [AGE_W-1:0]  age_a, age_b;
  logic              same_age, grant_a, grant_b, load_a, load_b;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  write_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_a (
    .clk(clk), .reset(reset), .load_i(load_a), .clear_i(grant_a),
    .addr_i(bus.reqAddrA), .data_i(bus.reqDataA), .stamp_i(cnt_q),
    .full_o(full_a), .addr_o(addr_a), .data_o(data_a), .stamp_o(stamp_a)
  );

  write_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_b (
    .clk(clk), .reset(reset), .load_i(load_b), .clear_i(grant_b),
    .addr_i(bus.reqAddrB), .data_i(bus.reqDataB), .stamp_i(cnt_q),
    .full_o(full_b), .addr_o(addr_b), .data_o(data_b), .stamp_o(stamp_b)
  );

  // Equal stamps only happen when both slots were loaded on the same edge.
  assign age_a    = age_of(cnt_q, stamp_a);
  assign age_b    = age_of(cnt_q, stamp_b);
  assign same_age = (stamp_a == stamp_b);
  assign grant_a  = full_a && (!full_b || (same_age ? (ptr_q == REQ_A) : (age_a > age_b)));
  assign grant_b  = full_b && !grant_a;

  assign bus.reqReadyA = !full_a || grant_a;
  assign bus.reqReadyB = !full_b || grant_b;
  assign load_a        = bus.reqValidA && bus.reqReadyA;
  assign load_b        = bus.reqValidB && bus.reqReadyB;

  assign sel_addr = grant_a ? addr_a : addr_b;
  assign sel_data = grant_a ? data_a : data_b;

  always_comb begin
    we_d   = 1'b0;
    drop_d = 1'b0;
    wa_d   = wa_q;
    wd_d   = wd_q;
    ptr_d  = ptr_q;
    if (grant_a || grant_b) begin
      if (in_range(sel_addr)) begin
        we_d = 1'b1;
        wa_d = sel_addr;
        wd_d = sel_data;
      end else begin
        drop_d = 1'b1;
      end
      if (full_a && full_b && same_age) begin
        ptr_d = (ptr_q == REQ_A) ? REQ_B : REQ_A;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      ptr_q  <= REQ_A;
      we_q   <= 1'b0;
      drop_q <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      drop_q <= drop_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
    end
  end

  assign bus.writeEn      = we_q;
  assign bus.writeAddress = wa_q;
  assign bus.writeData    = wd_q;
  assign bus.dropErr      = drop_q;
  assign bus.idle         = !full_a && !full_b && !we_q;

`ifdef REG_FWD_EN
  // B is the newer slot if it was loaded later, or on the same edge while
  // the pointer still favours A (so B will issue after A).
  logic b_younger;
  assign b_younger = full_b && (!full_a || (same_age ? (ptr_q == REQ_A) : (age_b < age_a)));

  // Lowest priority assigned first so that later matches override.
  function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] key);
    logic [DATA_W:0] res;
    logic            hit_a, hit_b;
    res   = '0;
    hit_a = full_a && (addr_a == key) && in_range(addr_a);
    hit_b = full_b && (addr_b == key) && in_range(addr_b);
    if (we_q && (wa_q == key)) res = {1'b1, wd_q};
    if (b_younger) begin
      if (hit_a) res = {1'b1, data_a};
      if (hit_b) res = {1'b1, data_b};
    end else begin
      if (hit_b) res = {1'b1, data_b};
      if (hit_a) res = {1'b1, data_a};
    end
    return res;
  endfunction

  assign {bus.fwdHitA, bus.fwdDataA} = fwd_lookup(bus.fwdAddrA);
  assign {bus.fwdHitB, bus.fwdDataB} = fwd_lookup(bus.fwdAddrB);
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  import regfile_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: each slot holds one pending write tagged with the
  // absolute cycle number of its handshake; the smallest tag issues first.
  bit          m_fa, m_fb, m_rr, m_we, m_drop, m_known;
  int          m_sa, m_sb, m_cyc;
  logic [AW-1:0] m_aa, m_ab, m_wa;
  logic [DW-1:0] m_da, m_db, m_wd;
  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] d_regs [NR];

  function automatic int m_grant();
    if (m_fa && m_fb) begin
      if (m_sa < m_sb) return 1;
      if (m_sb < m_sa) return 2;
      return m_rr ? 2 : 1;
    end
    if (m_fa) return 1;
    if (m_fb) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin : model
    int g;
    bit rdy_a, rdy_b;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    if (reset) begin
      m_fa = 0; m_fb = 0; m_rr = 0; m_we = 0; m_drop = 0;
      m_known = 1; m_wa = '0; m_wd = '0;
    end else begin
      g = m_grant();
      m_we = 0;
      m_drop = 0;
      if (g != 0) begin
        ga = (g == 1) ? m_aa : m_ab;
        gd = (g == 1) ? m_da : m_db;
        if (ga < NR) begin
          m_we = 1; m_wa = ga; m_wd = gd; m_known = 1;
          m_regs[ga[4:0]] = gd;
        end else begin
          m_drop = 1; m_known = 0;
        end
        if (m_fa && m_fb && m_sa == m_sb) m_rr = !m_rr;
      end
      rdy_a = !m_fa || g == 1;
      rdy_b = !m_fb || g == 2;
      if (bus.reqValidA && rdy_a) begin
        m_fa = 1; m_sa = m_cyc; m_aa = bus.reqAddrA; m_da = bus.reqDataA;
      end else if (g == 1) m_fa = 0;
      if (bus.reqValidB && rdy_b) begin
        m_fb = 1; m_sb = m_cyc; m_ab = bus.reqAddrB; m_db = bus.reqDataB;
      end else if (g == 2) m_fb = 0;
    end
    m_cyc++;
  end

  always @(negedge clk) begin : cmp
    int g;
    if (chk_en) begin
      g = m_grant();
      chk("writeEn", 64'(bus.writeEn), 64'(m_we));
      chk("dropErr", 64'(bus.dropErr), 64'(m_drop));
      chk("idle", 64'(bus.idle), 64'(!m_fa && !m_fb && !m_we));
      chk("reqReadyA", 64'(bus.reqReadyA), 64'(!m_fa || g == 1));
      chk("reqReadyB", 64'(bus.reqReadyB), 64'(!m_fb || g == 2));
      if (m_known) begin
        chk("writeAddress", 64'(bus.writeAddress), 64'(m_wa));
        chk("writeData", 64'(bus.writeData), 64'(m_wd));
      end
      if (bus.writeEn === 1'b1 && bus.writeAddress < NR)
        d_regs[bus.writeAddress[4:0]] = bus.writeData;
    end
  end

  task automatic send(input bit va, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input bit vb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    bus.reqValidA = va; bus.reqAddrA = aa; bus.reqDataA = da;
    bus.reqValidB = vb; bus.reqAddrB = ab; bus.reqDataB = db;
    @(posedge clk); #1;
    bus.reqValidA = 1'b0;
    bus.reqValidB = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      d_regs[i] = '0;
    end
    m_cyc = 0;
    reset = 1'b1;
    bus.reqValidA = 1'b0; bus.reqAddrA = '0; bus.reqDataA = '0;
    bus.reqValidB = 1'b0; bus.reqAddrB = '0; bus.reqDataB = '0;
`ifdef REG_FWD_EN
    bus.fwdAddrA = '0;
    bus.fwdAddrB = '0;
`endif
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_writeEn", 64'(bus.writeEn), 64'd0);
    chk("rst_readyA", 64'(bus.reqReadyA), 64'd1);
    chk("rst_readyB", 64'(bus.reqReadyB), 64'd1);
    chk("rst_idle", 64'(bus.idle), 64'd1);
    chk("rst_addr", 64'(bus.writeAddress), 64'd0);
    chk("rst_data", 64'(bus.writeData), 64'd0);
    chk("rst_drop", 64'(bus.dropErr), 64'd0);

    // single write A: addr 3, data 5
    send(1, 16'd3, 32'h5, 0, '0, '0);
    @(negedge clk);
    chk("single_not_yet", 64'(bus.writeEn), 64'd0);
    @(negedge clk);
    chk("single_we", 64'(bus.writeEn), 64'd1);
    chk("single_addr", 64'(bus.writeAddress), 64'd3);
    chk("single_data", 64'(bus.writeData), 64'h5);
    @(negedge clk);
    chk("single_we_off", 64'(bus.writeEn), 64'd0);
    chk("single_idle", 64'(bus.idle), 64'd1);

    // same-edge collision, pointer at A after reset
    send(1, 16'd4, 32'h6, 1, 16'd4, 32'h9);
    @(negedge clk);
    @(negedge clk);
    chk("coll_first_addr", 64'(bus.writeAddress), 64'd4);
    chk("coll_first_data", 64'(bus.writeData), 64'h6);
    @(negedge clk);
    chk("coll_second_we", 64'(bus.writeEn), 64'd1);
    chk("coll_second_data", 64'(bus.writeData), 64'h9);
    @(negedge clk); #1;
    chk("coll_reg4", 64'(d_regs[4]), 64'h9);
    chk("model_reg4", 64'(m_regs[4]), 64'h9);

    // age ordering: B first, A one edge later
    send(0, '0, '0, 1, 16'd1, 32'h3);
    send(1, 16'd2, 32'h4, 0, '0, '0);
    @(negedge clk);
    chk("age_first_addr", 64'(bus.writeAddress), 64'd1);
    chk("age_first_data", 64'(bus.writeData), 64'h3);
    @(negedge clk);
    chk("age_second_addr", 64'(bus.writeAddress), 64'd2);
    chk("age_second_data", 64'(bus.writeData), 64'h4);

    // out-of-range write from B
    @(negedge clk);
    send(0, '0, '0, 1, 16'd40, 32'h77);
    @(negedge clk);
    chk("oor_drop_early", 64'(bus.dropErr), 64'd0);
    @(negedge clk);
    chk("oor_we", 64'(bus.writeEn), 64'd0);
    chk("oor_drop", 64'(bus.dropErr), 64'd1);
    @(negedge clk);
    chk("oor_drop_gone", 64'(bus.dropErr), 64'd0);

    // reset with both slots full
    send(1, 16'd10, 32'hA1, 1, 16'd11, 32'hB1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mrst_we", 64'(bus.writeEn), 64'd0);
    chk("mrst_idle", 64'(bus.idle), 64'd1);
    chk("mrst_readyA", 64'(bus.reqReadyA), 64'd1);
    repeat (3) @(negedge clk);
    chk("mrst_no_pulse", 64'(bus.writeEn), 64'd0);
    send(1, 16'd7, 32'h71, 1, 16'd7, 32'h72);
    @(negedge clk);
    @(negedge clk);
    chk("mrst_ptr_a_data", 64'(bus.writeData), 64'h71);
    @(negedge clk);
    chk("mrst_ptr_b_data", 64'(bus.writeData), 64'h72);

`ifdef REG_FWD_EN
    @(negedge clk);
    send(1, 16'd7, 32'hAA, 0, '0, '0);
    bus.fwdAddrA = 16'd7;
    bus.fwdAddrB = 16'd9;
    #1;
    chk("fwd_hitA", 64'(bus.fwdHitA), 64'd1);
    chk("fwd_dataA", 64'(bus.fwdDataA), 64'hAA);
    chk("fwd_missB", 64'(bus.fwdHitB), 64'd0);
`endif

    // both continuously valid: alternating issue
    for (int i = 0; i < 8; i++) begin
      bus.reqValidA = 1'b1; bus.reqAddrA = 16'(i);      bus.reqDataA = 32'(100 + i);
      bus.reqValidB = 1'b1; bus.reqAddrB = 16'(i + 16); bus.reqDataB = 32'(200 + i);
      @(posedge clk); #1;
    end

    // random traffic including out-of-range addresses
    for (int i = 0; i < 300; i++) begin
      bus.reqValidA = 1'($urandom_range(0, 1));
      bus.reqAddrA  = 16'($urandom_range(0, 39));
      bus.reqDataA  = $urandom;
      bus.reqValidB = 1'($urandom_range(0, 1));
      bus.reqAddrB  = 16'($urandom_range(0, 39));
      bus.reqDataB  = $urandom;
      @(posedge clk); #1;
    end
    bus.reqValidA = 1'b0;
    bus.reqValidB = 1'b0;
    repeat (5) @(negedge clk);
    chk("final_idle", 64'(bus.idle), 64'd1);
    for (int i = 0; i < NR; i++) chk("regfile_image", 64'(d_regs[i]), 64'(m_regs[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
